// File: rtl/sdm_dac_core.sv
// -----------------------------------------------------------------------------
// sdm_dac_core -- 1-bit sigma-delta DAC modulator, 1st or 2nd order (CIFB).
//
// Samples enter through a valid/ready handshake into a 1-deep holding
// register. Every OSR cycles (a "tick") the held sample moves into the loop
// input x_cur. The loop integrators saturate instead of wrapping, so an
// overloaded 2nd-order loop pins high or low rather than flipping sign.
//
// Parameters:
//   N      signed input sample width
//   ORDER  modulator order, 1 or 2
//   OSR    clk_25 cycles per input sample (2..65535)
//
// Ports:
//   clk_25       modulator clock
//   areset       asynchronous reset, active low
//   en           enable; low clears the loop state synchronously
//   din          signed sample
//   din_valid    din qualifier
//   din_ready    holding register empty
//   sample_tick  pulse when a sample enters the loop (or an underrun occurs)
//   clr_status   synchronous clear of the sticky flags
//   underrun     sticky: tick with an empty holding register
//   ovf          sticky: an integrator clamped
//   pdm          registered 1-bit output
//
// Build option: define SDM_DITHER_EN to add a 16-bit LFSR dither (-8..+7)
// to the quantiser input. Without it the dither term is zero and no LFSR
// is built.
// -----------------------------------------------------------------------------

// Saturating accumulate: sum = sat(acc + sext(add) - sub).
module sdm_sat_int #(
  parameter int W  = 18,
  parameter int AW = 16
) (
  input  logic signed [W-1:0]  acc,
  input  logic signed [AW-1:0] add,
  input  logic signed [W-1:0]  sub,
  output logic signed [W-1:0]  sum,
  output logic                 clamp
);
  // Two guard bits cover the worst case of three near-full-scale operands.
  localparam int XW = W + 2;
  localparam logic signed [XW-1:0] MAX_X = {3'b000, {(W-1){1'b1}}};
  localparam logic signed [XW-1:0] MIN_X = {3'b111, {(W-1){1'b0}}};
  localparam logic signed [W-1:0]  MAX_W = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0]  MIN_W = {1'b1, {(W-1){1'b0}}};

  logic signed [XW-1:0] raw;

  always_comb begin
    raw   = {{2{acc[W-1]}}, acc} + {{(XW-AW){add[AW-1]}}, add}
          - {{2{sub[W-1]}}, sub};
    sum   = raw[W-1:0];
    clamp = 1'b0;
    if (raw > MAX_X) begin
      sum   = MAX_W;
      clamp = 1'b1;
    end else if (raw < MIN_X) begin
      sum   = MIN_W;
      clamp = 1'b1;
    end
  end
endmodule

module sdm_dac_core #(
  parameter int N     = 16,
  parameter int ORDER = 2,
  parameter int OSR   = 64
) (
  input  logic         clk_25,
  input  logic         areset,
  input  logic         en,
  input  logic [N-1:0] din,
  input  logic         din_valid,
  output logic         din_ready,
  output logic         sample_tick,
  input  logic         clr_status,
  output logic         underrun,
  output logic         ovf,
  output logic         pdm
);
  localparam int W1 = N + 2;
  localparam int W2 = N + 4;
  localparam int PW = (OSR > 2) ? $clog2(OSR) : 1;
  localparam logic [PW-1:0] PH_LAST = PW'(OSR - 1);
  // Feedback magnitude 2^(N-1), carried at the widest integrator width.
  localparam logic signed [W2-1:0] FB_POS = {{(W2-N){1'b0}}, 1'b1, {(N-1){1'b0}}};

  if (ORDER != 1 && ORDER != 2) begin : g_bad_order
    $error("sdm_dac_core: ORDER must be 1 or 2");
  end
  if (OSR < 2 || OSR > 65535) begin : g_bad_osr
    $error("sdm_dac_core: OSR must be in 2..65535");
  end

  logic signed [W1-1:0] i1_q, i1_d, i1_n;
  logic signed [W2-1:0] i2_q, i2_d, i2_n;
  logic signed [N-1:0]  x_cur_q, x_cur_d, hold_q, hold_d;
  logic                 hold_full_q, hold_full_d;
  logic [PW-1:0]        phase_q, phase_d;
  logic                 pdm_q, pdm_d;
  logic                 underrun_q, underrun_d;
  logic                 ovf_q, ovf_d;
  logic                 clamp1, clamp2;
  logic                 tick;
  logic signed [W2-1:0] fb;
  logic signed [W2-1:0] loop_v;
  logic signed [W2:0]   q;
  logic signed [4:0]    dither;

  assign fb = pdm_q ? FB_POS : -FB_POS;

  sdm_sat_int #(.W(W1), .AW(N)) u_int1 (
    .acc   (i1_q),
    .add   (x_cur_q),
    .sub   (fb[W1-1:0]),
    .sum   (i1_n),
    .clamp (clamp1)
  );

  if (ORDER == 2) begin : g_ord2
    // Second stage integrates the already-updated first stage (CIFB).
    sdm_sat_int #(.W(W2), .AW(W1)) u_int2 (
      .acc   (i2_q),
      .add   (i1_n),
      .sub   (fb),
      .sum   (i2_n),
      .clamp (clamp2)
    );
  end else begin : g_ord1
    assign i2_n   = '0;
    assign clamp2 = 1'b0;
  end

`ifdef SDM_DITHER_EN
  logic [15:0] lfsr_q, lfsr_d;
  logic        lfsr_fb;

  // Fibonacci LFSR, taps 16,14,13,11 in right-shift form; reseeded while
  // disabled so every enable starts the same dither sequence.
  always_comb begin
    lfsr_fb = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];
    lfsr_d  = en ? {lfsr_fb, lfsr_q[15:1]} : 16'hACE1;
  end

  always_ff @(posedge clk_25 or negedge areset) begin
    if (!areset) lfsr_q <= 16'hACE1;
    else         lfsr_q <= lfsr_d;
  end

  assign dither = $signed({1'b0, lfsr_q[3:0]}) - 5'sd8;
`else
  assign dither = '0;
`endif

  always_comb begin
    tick = en & (phase_q == PH_LAST);

    // Quantiser input, widened by one bit so adding dither cannot wrap.
    loop_v = (ORDER == 1) ? {{(W2-W1){i1_n[W1-1]}}, i1_n} : i2_n;
    q      = {loop_v[W2-1], loop_v} + {{(W2-4){dither[4]}}, dither};

    if (en) begin
      phase_d = tick ? '0 : phase_q + 1'b1;
      i1_d    = i1_n;
      i2_d    = i2_n;
      pdm_d   = ~q[W2];
    end else begin
      phase_d = '0;
      i1_d    = '0;
      i2_d    = '0;
      pdm_d   = 1'b0;
    end

    // Tick unload and handshake load never collide: ready is low while full.
    x_cur_d     = x_cur_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    if (tick && hold_full_q) begin
      x_cur_d     = hold_q;
      hold_full_d = 1'b0;
    end else if (din_valid && !hold_full_q) begin
      hold_d      = din;
      hold_full_d = 1'b1;
    end

    // Sticky flags: a set in the same cycle as clr_status wins.
    underrun_d = (tick & ~hold_full_q) | (underrun_q & ~clr_status);
    ovf_d      = (en & (clamp1 | clamp2)) | (ovf_q & ~clr_status);
  end

  always_ff @(posedge clk_25 or negedge areset) begin
    if (!areset) begin
      i1_q        <= '0;
      i2_q        <= '0;
      x_cur_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      phase_q     <= '0;
      pdm_q       <= 1'b0;
      underrun_q  <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      i1_q        <= i1_d;
      i2_q        <= i2_d;
      x_cur_q     <= x_cur_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      phase_q     <= phase_d;
      pdm_q       <= pdm_d;
      underrun_q  <= underrun_d;
      ovf_q       <= ovf_d;
    end
  end

  assign din_ready   = ~hold_full_q;
  assign sample_tick = tick;
  assign underrun    = underrun_q;
  assign ovf         = ovf_q;
  assign pdm         = pdm_q;
endmodule

// File: tb/tb_sdm_dac_core.sv
// -----------------------------------------------------------------------------
// tb_sdm_dac_core -- drives a 1st-order and a 2nd-order modulator (OSR=8)
// with shared stimulus. A behavioural model pushes the expected registered
// outputs of both instances into a scoreboard each cycle; they are popped
// and compared after the clock edge. Directed checks cover handshake timing,
// flags, density, overload and reset/enable behaviour.
// -----------------------------------------------------------------------------
module tb_sdm_dac_core;
  localparam int N   = 16;
  localparam int OSR = 8;
  localparam longint FB    = 64'sd1 <<< (N - 1);
  localparam longint I1MAX = (64'sd1 <<< (N + 1)) - 1;
  localparam longint I1MIN = -(64'sd1 <<< (N + 1));
  localparam longint I2MAX = (64'sd1 <<< (N + 3)) - 1;
  localparam longint I2MIN = -(64'sd1 <<< (N + 3));

  logic               clk_25 = 1'b0;
  logic               areset, en, din_valid, clr_status;
  logic signed [N-1:0] din;
  logic rdy1, tick1, urun1, ovf1, pdm1;
  logic rdy2, tick2, urun2, ovf2, pdm2;

  always #20 clk_25 = ~clk_25;

  sdm_dac_core #(.N(N), .ORDER(1), .OSR(OSR)) u_dut1 (
    .clk_25(clk_25), .areset(areset), .en(en), .din(din), .din_valid(din_valid),
    .din_ready(rdy1), .sample_tick(tick1), .clr_status(clr_status),
    .underrun(urun1), .ovf(ovf1), .pdm(pdm1));

  sdm_dac_core #(.N(N), .ORDER(2), .OSR(OSR)) u_dut2 (
    .clk_25(clk_25), .areset(areset), .en(en), .din(din), .din_valid(din_valid),
    .din_ready(rdy2), .sample_tick(tick2), .clr_status(clr_status),
    .underrun(urun2), .ovf(ovf2), .pdm(pdm2));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  longint      m_i1[2], m_i2[2];
  bit          m_pdm[2], m_ovf[2];
  longint      m_x, m_hold;
  bit          m_full, m_urun;
  int          m_phase;
  logic [15:0] m_lfsr;
  logic [9:0]  sb[$];

  function automatic logic [9:0] obs();
    return {pdm1, ovf1, urun1, rdy1, tick1, pdm2, ovf2, urun2, rdy2, tick2};
  endfunction

  function automatic void m_reset();
    for (int d = 0; d < 2; d++) begin
      m_i1[d] = 0; m_i2[d] = 0; m_pdm[d] = 0; m_ovf[d] = 0;
    end
    m_x = 0; m_hold = 0; m_full = 0; m_urun = 0; m_phase = 0;
    m_lfsr = 16'hACE1;
    sb.delete();
  endfunction

  // Advance the model one clock using the inputs currently applied, and
  // queue the outputs both DUTs should show after the edge.
  function automatic void m_step();
    bit     tick, ntick, set;
    longint fbv, s1, s2, q, dith;
    tick = en && (m_phase == OSR - 1);
    dith = 0;
`ifdef SDM_DITHER_EN
    dith = longint'(m_lfsr[3:0]) - 8;
`endif
    for (int d = 0; d < 2; d++) begin
      set = 0;
      if (en) begin
        fbv = m_pdm[d] ? FB : -FB;
        s1  = m_i1[d] + m_x - fbv;
        if (s1 > I1MAX) begin s1 = I1MAX; set = 1; end
        if (s1 < I1MIN) begin s1 = I1MIN; set = 1; end
        s2 = 0;
        if (d == 1) begin
          s2 = m_i2[d] + s1 - fbv;
          if (s2 > I2MAX) begin s2 = I2MAX; set = 1; end
          if (s2 < I2MIN) begin s2 = I2MIN; set = 1; end
        end
        q = ((d == 0) ? s1 : s2) + dith;
        m_i1[d] = s1; m_i2[d] = s2; m_pdm[d] = (q >= 0);
      end else begin
        m_i1[d] = 0; m_i2[d] = 0; m_pdm[d] = 0;
      end
      m_ovf[d] = set | (m_ovf[d] & !clr_status);
    end
    m_urun = (tick && !m_full) | (m_urun & !clr_status);
    if (tick && m_full) begin
      m_x = m_hold; m_full = 0;
    end else if (din_valid && !m_full) begin
      m_hold = longint'(din); m_full = 1;
    end
    m_phase = (!en || tick) ? 0 : m_phase + 1;
`ifdef SDM_DITHER_EN
    if (!en) m_lfsr = 16'hACE1;
    else     m_lfsr = {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
`endif
    ntick = en && (m_phase == OSR - 1);
    sb.push_back({m_pdm[0], m_ovf[0], m_urun, !m_full, ntick,
                  m_pdm[1], m_ovf[1], m_urun, !m_full, ntick});
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    logic [9:0] e;
    #1;
    m_step();
    @(posedge clk_25);
    #1;
    e = sb.pop_front();
    chk("cyc", obs(), e);
    @(negedge clk_25);
  endtask

  task automatic run(input int n, output int ones1, output int ones2, output int zmax2);
    int z;
    ones1 = 0; ones2 = 0; zmax2 = 0; z = 0;
    repeat (n) begin
      cyc();
      ones1 += int'(pdm1);
      ones2 += int'(pdm2);
      if (!pdm2) begin
        z++;
        if (z > zmax2) zmax2 = z;
      end else z = 0;
    end
  endtask

  // Asserted mid-cycle: outputs must reach reset values without a clock.
  task automatic do_reset();
    @(negedge clk_25);
    areset = 0; en = 0; din_valid = 0; clr_status = 0;
    #1;
    m_reset();
    chk("reset_outs", obs(), 10'b00010_00010);
    repeat (2) @(negedge clk_25);
    areset = 1;
  endtask

  initial begin
    #4000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int o1, o2, zm;
    areset = 0; en = 0; din = '0; din_valid = 0; clr_status = 0;

    // Reset state
    do_reset();

    // Handshake, tick timing, underrun and clr_status precedence
    for (int c = 0; c < 25; c++) begin
      en = 1; din = 16'sd100; din_valid = (c == 0); clr_status = (c == 17 || c == 23);
      #1;
      chk($sformatf("tick c=%0d", c), tick1, (c % 8) == 7);
      chk($sformatf("ready c=%0d", c), rdy1, (c == 0) || (c >= 8));
      if (c == 9)  chk("urun_first_tick", urun1, 0);
      if (c == 16) chk("urun_set", urun1, 1);
      if (c == 18) chk("urun_clr", urun1, 0);
      if (c == 24) chk("urun_set_wins", urun1, 1);
      cyc();
    end
    clr_status = 0;

    // Order-1 zero input
    do_reset();
    en = 1; din = 16'sd0; din_valid = 1;
    run(24, o1, o2, zm);
    run(1024, o1, o2, zm);
    chk($sformatf("o1_zero ones=%0d", o1), (o1 >= 510 && o1 <= 514), 1);
    chk("o1_zero_flags", {ovf1, urun1}, 2'b00);

    // Order-1 half-scale positive input
    din = 16'sd16384;
    run(24, o1, o2, zm);
    run(1024, o1, o2, zm);
    chk($sformatf("o1_pos ones=%0d", o1), (o1 >= 766 && o1 <= 770), 1);

    // Order-1 negative full scale: pdm settles to constant 0 without overflow
    din = -16'sd32768;
    run(24, o1, o2, zm);
    run(64, o1, o2, zm);
    chk("o1_negfs_ones", o1, 0);
    chk("o1_negfs_ovf", ovf1, 0);

    // Order-2 negative input
    do_reset();
    en = 1; din = -16'sd8192; din_valid = 1;
    run(24, o1, o2, zm);
    run(4096, o1, o2, zm);
    chk($sformatf("o2_neg ones=%0d", o2), (o2 >= 1532 && o2 <= 1540), 1);
    chk("o2_neg_ovf", ovf2, 0);

    // Order-2 overload: saturates, never wraps
    do_reset();
    en = 1; din = 16'sd32767; din_valid = 1;
    run(64, o1, o2, zm);
    chk("ovl_ovf", ovf2, 1);
    run(200, o1, o2, zm);
    chk($sformatf("ovl_zero_run=%0d", zm), (zm <= 2), 1);
    chk("ovl_i2_pinned", 64'(u_dut2.i2_q), 64'd524287);

    // en=0 clears pdm next cycle; re-enable gives first tick OSR cycles later
    en = 0; din_valid = 0;
    cyc();
    chk("en0_pdm", {pdm1, pdm2}, 2'b00);
    chk("en0_ovf_held", ovf2, 1);
    for (int c = 0; c < 8; c++) begin
      en = 1;
      #1;
      chk($sformatf("reen_tick c=%0d", c), tick1, c == 7);
      cyc();
    end
    din_valid = 1;
    cyc();
    din_valid = 0;
    chk("hold_full", rdy1, 0);

    // Mid-stream reset drops the held sample: first tick underruns
    do_reset();
    for (int c = 0; c < 9; c++) begin
      en = 1; din_valid = 0;
      #1;
      if (c == 8) chk("hold_lost_urun", urun1, 1);
      cyc();
    end

    // Disabled modulator still accepts one sample; flags are held
    en = 0; din_valid = 1; din = 16'sd1234;
    cyc();
    din_valid = 0;
    cyc();
    chk("en0_accept", {rdy1, urun1}, 2'b01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
